// File: rtl/cam_lookup_controller.sv
// cam_lookup_controller: request/response sequencer in front of a 16x8 CAM.
// Handles empty-fill of the array, contiguous slot allocation and duplicate
// suppression so that user logic never addresses the CAM directly.
module cam_lookup_controller #(
  parameter logic [7:0] EMPTY_KEY = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_key,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_hit,
  output logic [3:0] rsp_addr,
  output logic       rsp_new,
  output logic       rsp_full,
  output logic       rsp_err,
  output logic [4:0] count,
  output logic       full,
  output logic       cam_wen,
  output logic       cam_ren,
  output logic [7:0] cam_din,
  output logic [3:0] cam_addr,
  input  logic [3:0] cam_dout,
  input  logic       cam_hit
);

  localparam logic [1:0] OP_SEARCH = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOOKUP,
    ST_CAPTURE,
    ST_WRITE,
    ST_RESP
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] ptr_reg, ptr_next;
  logic [4:0] count_reg, count_next;
  logic [1:0] op_reg, op_next;
  logic [7:0] key_reg, key_next;
  logic       rsp_hit_reg, rsp_hit_next;
  logic [3:0] rsp_addr_reg, rsp_addr_next;
  logic       rsp_new_reg, rsp_new_next;
  logic       rsp_full_reg, rsp_full_next;
  logic       rsp_err_reg, rsp_err_next;

  // State register: reset restarts the empty-fill from slot 0 and forgets all entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_INIT;
      ptr_reg      <= 4'd0;
      count_reg    <= 5'd0;
      op_reg       <= OP_SEARCH;
      key_reg      <= 8'd0;
      rsp_hit_reg  <= 1'b0;
      rsp_addr_reg <= 4'd0;
      rsp_new_reg  <= 1'b0;
      rsp_full_reg <= 1'b0;
      rsp_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      count_reg    <= count_next;
      op_reg       <= op_next;
      key_reg      <= key_next;
      rsp_hit_reg  <= rsp_hit_next;
      rsp_addr_reg <= rsp_addr_next;
      rsp_new_reg  <= rsp_new_next;
      rsp_full_reg <= rsp_full_next;
      rsp_err_reg  <= rsp_err_next;
    end
  end

  // Next-state logic and Moore output decode; outputs are forced low while rst is high.
  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    count_next    = count_reg;
    op_next       = op_reg;
    key_next      = key_reg;
    rsp_hit_next  = rsp_hit_reg;
    rsp_addr_next = rsp_addr_reg;
    rsp_new_next  = rsp_new_reg;
    rsp_full_next = rsp_full_reg;
    rsp_err_next  = rsp_err_reg;

    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_hit   = 1'b0;
    rsp_addr  = 4'd0;
    rsp_new   = 1'b0;
    rsp_full  = 1'b0;
    rsp_err   = 1'b0;
    count     = 5'd0;
    full      = 1'b0;
    cam_wen   = 1'b0;
    cam_ren   = 1'b0;
    cam_din   = 8'd0;
    cam_addr  = 4'd0;

    case (state_reg)
      ST_INIT: begin
        ptr_next = ptr_reg + 4'd1;
        if (ptr_reg == 4'd15) begin
          state_next = ST_IDLE;
          count_next = 5'd0;
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          op_next       = req_op;
          key_next      = req_key;
          rsp_hit_next  = 1'b0;
          rsp_addr_next = 4'd0;
          rsp_new_next  = 1'b0;
          rsp_full_next = 1'b0;
          rsp_err_next  = 1'b0;
          if (req_op == OP_CLEAR) begin
            ptr_next   = 4'd0;
            count_next = 5'd0;
            state_next = ST_INIT;
          end else if (req_op == OP_RSVD || req_key == EMPTY_KEY) begin
            rsp_err_next = 1'b1;
            state_next   = ST_RESP;
          end else begin
            state_next = ST_LOOKUP;
          end
        end
      end
      ST_LOOKUP: begin
        state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // Duplicate suppression keeps at most one match, so cam_dout is unambiguous.
        if (cam_hit) begin
          rsp_hit_next  = 1'b1;
          rsp_addr_next = cam_dout;
          state_next    = ST_RESP;
        end else if (op_reg != OP_INSERT) begin
          state_next = ST_RESP;
        end else if (count_reg == 5'd16) begin
          rsp_full_next = 1'b1;
          state_next    = ST_RESP;
        end else begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // New keys are appended at count so valid slots stay contiguous.
        rsp_new_next  = 1'b1;
        rsp_addr_next = count_reg[3:0];
        count_next    = count_reg + 5'd1;
        state_next    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_INIT;
        ptr_next   = 4'd0;
        count_next = 5'd0;
      end
    endcase

    if (!rst) begin
      count   = count_reg;
      full    = (count_reg == 5'd16);
      cam_din = key_reg;
      case (state_reg)
        ST_INIT: begin
          cam_wen  = 1'b1;
          cam_addr = ptr_reg;
          cam_din  = EMPTY_KEY;
        end
        ST_IDLE:   req_ready = 1'b1;
        ST_LOOKUP: cam_ren = 1'b1;
        ST_WRITE: begin
          cam_wen  = 1'b1;
          cam_addr = count_reg[3:0];
        end
        ST_RESP: begin
          rsp_valid = 1'b1;
          rsp_hit   = rsp_hit_reg;
          rsp_addr  = rsp_addr_reg;
          rsp_new   = rsp_new_reg;
          rsp_full  = rsp_full_reg;
          rsp_err   = rsp_err_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_lookup_controller.sv
// Testbench for cam_lookup_controller: behavioural CAM plus a queue-based
// reference of the stored key list; randomized request mix with directed cases.
module tb_cam_lookup_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'd0;
  logic [7:0] req_key = 8'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       rsp_hit;
  logic [3:0] rsp_addr;
  logic       rsp_new;
  logic       rsp_full;
  logic       rsp_err;
  logic [4:0] count;
  logic       full;
  logic       cam_wen;
  logic       cam_ren;
  logic [7:0] cam_din;
  logic [3:0] cam_addr;
  logic [3:0] cam_dout = 4'd0;
  logic       cam_hit = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] ref_q[$];
  logic [7:0] cam_mem[16];

  always #5 clk = ~clk;

  cam_lookup_controller dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_addr(rsp_addr),
    .rsp_new(rsp_new), .rsp_full(rsp_full), .rsp_err(rsp_err),
    .count(count), .full(full),
    .cam_wen(cam_wen), .cam_ren(cam_ren), .cam_din(cam_din), .cam_addr(cam_addr),
    .cam_dout(cam_dout), .cam_hit(cam_hit)
  );

  // Behavioural CAM: registered search result, highest index wins.
  function automatic logic [4:0] cam_search(input logic [7:0] k);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 0; i < 16; i++)
      if (cam_mem[i] == k) r = {1'b1, 4'(i)};
    return r;
  endfunction

  always @(posedge clk) begin
    if (cam_wen) cam_mem[cam_addr] <= cam_din;
    if (cam_ren) {cam_hit, cam_dout} <= cam_search(cam_din);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expects to be called just after the edge that entered the fill sequence.
  task automatic check_init();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("init_wen", cam_wen, 1);
      chk("init_addr", cam_addr, i);
      chk("init_din", cam_din, 8'hFF);
      chk("init_ren", cam_ren, 0);
      chk("init_ready", req_ready, 0);
    end
    @(negedge clk);
    chk("init_done_ready", req_ready, 1);
    chk("init_done_wen", cam_wen, 0);
    chk("init_count", count, 0);
    chk("init_full", full, 0);
    ref_q.delete();
    $display("txn init/clear done count=%0d", count);
  endtask

  task automatic wait_ready(output bit ok);
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    ok = req_ready;
    if (!ok) chk("req_ready_timeout", 0, 1);
  endtask

  task automatic do_clear();
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1; req_op = 2'b10; req_key = 8'($urandom);
    @(posedge clk); #1 req_valid = 1'b0;
    check_init();
  endtask

  task automatic do_req(input logic [1:0] op, input logic [7:0] key, input int hold);
    bit ok;
    int idx = -1;
    int lat = 0, wens = 0, rens = 0;
    logic e_hit = 0, e_new = 0, e_full = 0, e_err = 0;
    logic [3:0] e_addr = 0;
    int e_lat, e_wens, e_rens;
    foreach (ref_q[i]) if (ref_q[i] == key) idx = i;
    if (op == 2'b11 || key == 8'hFF) begin
      e_err = 1; e_lat = 1;
    end else if (idx >= 0) begin
      e_hit = 1; e_addr = 4'(idx); e_lat = 3;
    end else if (op == 2'b00) begin
      e_lat = 3;
    end else if (ref_q.size() < 16) begin
      e_new = 1; e_addr = 4'(ref_q.size()); e_lat = 4;
    end else begin
      e_full = 1; e_lat = 3;
    end
    e_wens = e_new ? 1 : 0;
    e_rens = e_err ? 0 : 1;

    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1; req_op = op; req_key = key;
    @(posedge clk); #1 req_valid = 1'b0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      wens += int'(cam_wen);
      rens += int'(cam_ren);
      chk("wen_ren_excl", cam_wen & cam_ren, 0);
      if (cam_wen) begin
        chk("write_addr", cam_addr, e_addr);
        chk("write_din", cam_din, key);
      end
      if (cam_ren) chk("search_din", cam_din, key);
      if (rsp_valid) break;
    end
    if (!rsp_valid) begin
      chk("rsp_timeout", 0, 1);
      return;
    end
    if (e_new) ref_q.push_back(key);
    chk("latency", lat, e_lat);
    chk("cam_wen_cycles", wens, e_wens);
    chk("cam_ren_cycles", rens, e_rens);
    chk("rsp_hit", rsp_hit, e_hit);
    chk("rsp_addr", rsp_addr, e_addr);
    chk("rsp_new", rsp_new, e_new);
    chk("rsp_full", rsp_full, e_full);
    chk("rsp_err", rsp_err, e_err);
    chk("count", count, ref_q.size());
    chk("full", full, ref_q.size() == 16);
    chk("resp_ready_low", req_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_ready", req_ready, 0);
      chk("hold_fields", {rsp_hit, rsp_addr, rsp_new, rsp_full, rsp_err},
          {e_hit, e_addr, e_new, e_full, e_err});
    end
    $display("txn op=%0d key=%02h hit=%0d addr=%0d new=%0d full=%0d err=%0d lat=%0d count=%0d",
             op, key, rsp_hit, rsp_addr, rsp_new, rsp_full, rsp_err, lat, count);
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_valid", rsp_valid, 0);
    chk("post_hs_ready", req_ready, 1);
  endtask

  function automatic bit in_ref(input logic [7:0] k);
    foreach (ref_q[i]) if (ref_q[i] == k) return 1;
    return 0;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] k;
    int guard;
    bit ok;
    int w;
    for (int i = 0; i < 16; i++) cam_mem[i] = 8'(i * 3);

    // Reset: everything low while rst is high, then the 16-cycle fill.
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_wen", cam_wen, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_count", count, 0);
    @(posedge clk); #1 rst = 1'b0;
    check_init();

    // Insert / duplicate insert / basic searches.
    do_req(2'b01, 8'h3C, 0);
    do_req(2'b01, 8'h3C, 0);
    do_req(2'b01, 8'h10, 0);
    do_req(2'b01, 8'h20, 0);
    do_req(2'b00, 8'h20, 0);
    do_req(2'b00, 8'h55, 0);

    // Fill to 16 distinct keys, then overflow and existing-key insert.
    guard = 0;
    while (ref_q.size() < 16 && guard < 200) begin
      do_req(2'b01, 8'($urandom_range(0, 254)), 0);
      guard++;
    end
    chk("fill_count", count, 16);
    chk("fill_full", full, 1);
    k = 8'h99;
    while (in_ref(k)) k = k + 8'd1;
    do_req(2'b01, k, 0);
    do_req(2'b01, ref_q[5], 0);

    // Held response, then clear and search a previously stored key.
    k = ref_q[9];
    do_req(2'b00, k, 5);
    do_clear();
    do_req(2'b00, k, 0);

    // Error cases.
    do_req(2'b00, 8'hFF, 0);
    do_req(2'b11, 8'h42, 0);
    do_req(2'b01, 8'hFF, 1);

    // Randomized mix over a small key pool to exercise hits, fills and overflow.
    for (int t = 0; t < 80; t++) begin
      int r, hold;
      r = $urandom_range(0, 99);
      hold = $urandom_range(0, 3);
      k = ($urandom_range(0, 24) == 0) ? 8'hFF : 8'($urandom_range(0, 23) * 7 + 1);
      if (r < 3) do_clear();
      else if (r < 8) do_req(2'b11, k, hold);
      else if (r < 45) do_req(2'b00, k, hold);
      else do_req(2'b01, k, hold);
    end

    // Reset during WRITE of a new insert.
    do_clear();
    wait_ready(ok);
    req_valid = 1'b1; req_op = 2'b01; req_key = 8'h77;
    @(posedge clk); #1 req_valid = 1'b0;
    w = 0;
    @(negedge clk);
    while (!cam_wen && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("write_seen", cam_wen, 1);
    chk("write_seen_cycle", w, 2);
    rst = 1'b1;
    #1;
    chk("rst_mid_wen", cam_wen, 0);
    chk("rst_mid_valid", rsp_valid, 0);
    @(negedge clk);
    chk("rst_after_valid", rsp_valid, 0);
    chk("rst_after_count", count, 0);
    @(posedge clk); #1 rst = 1'b0;
    check_init();
    do_req(2'b00, 8'h77, 0);
    do_req(2'b01, 8'h77, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cam_lookup_controller.md
Name: cam_lookup_controller

Overview:
- Front-end sequencer for the 16-entry x 8-bit content addressable memory.
- Takes search, insert and clear requests on a valid/ready request channel and drives the CAM write/read-search port (wen/ren/din/addr).
- Captures the CAM's registered match result (dout/hit) and returns it on a valid/ready response channel.
- Owns slot allocation, duplicate suppression and the empty-fill of the array, so user logic never addresses the CAM directly.

Parameters:
EMPTY_KEY, 8'hFF, fill value written to unused slots; reserved, never a legal key.

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept request
req_op  in  2  00 search, 01 insert, 10 clear, 11 reserved
req_key  in  8  key for search/insert
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_hit  out  1  key found in a valid slot
rsp_addr  out  4  slot of hit, or slot newly written
rsp_new  out  1  insert wrote a new slot
rsp_full  out  1  insert missed and array full, nothing written
rsp_err  out  1  illegal op or key == EMPTY_KEY
count  out  5  occupied slots, 0..16
full  out  1  count == 16
cam_wen  out  1  CAM write enable
cam_ren  out  1  CAM search enable
cam_din  out  8  CAM key/data
cam_addr  out  4  CAM write address
cam_dout  in  4  CAM matched address; registered, valid the cycle after cam_ren
cam_hit  in  1  CAM match flag; registered, same timing as cam_dout

Behaviour:
Reset and outputs
- While rst is high, every output is 0 and state is forced to INIT with ptr = 0.
- Outputs are Moore-decoded from registered state.
- cam_wen and cam_ren are never high in the same cycle.

States
- INIT: cam_wen=1, cam_addr=ptr, cam_din=EMPTY_KEY; ptr increments each cycle. After ptr=15, go to IDLE with count=0. Occupies 16 cycles; req_ready=0.
- IDLE: req_ready=1. On req_valid, latch op/key.
  - op 10: ptr=0, count=0, go to INIT; no response is issued.
  - op 11, or key == EMPTY_KEY: go to RESP with rsp_err=1 and all other rsp fields 0.
  - Otherwise: go to LOOKUP.
- LOOKUP: cam_ren=1, cam_din=key; one cycle, then CAPTURE.
- CAPTURE: sample cam_hit/cam_dout.
  - Hit: rsp_hit=1, rsp_addr=cam_dout, then RESP.
  - Search miss: rsp_hit=0, rsp_addr=0, then RESP.
  - Insert miss with count<16: go to WRITE.
  - Insert miss with count==16: rsp_full=1, then RESP.
- WRITE: cam_wen=1, cam_addr=count[3:0], cam_din=key; rsp_new=1, rsp_addr=count[3:0]; count increments; then RESP.
- RESP: rsp_valid=1 with all rsp fields held stable until rsp_ready; return to IDLE on the handshake cycle. req_ready=0.

Slot and key rules
- Valid slots are always contiguous at 0..count-1. Slots at count..15 hold EMPTY_KEY.
- Duplicate suppression guarantees at most one match, so the CAM's highest-index priority never masks an entry.

Latency (request accepted in cycle 0)
- Search or dup-insert: rsp_valid in cycle 3.
- New insert: rsp_valid in cycle 4.
- Error: rsp_valid in cycle 1.
- Clear: req_ready returns in cycle 17.

Boundary cases
- Back-to-back requests: the next request is accepted no earlier than the cycle after the response handshake.
- rst mid-operation (any state): abandon the transaction, drop rsp_valid, count=0, re-run INIT.
- cam_din: key outside INIT; EMPTY_KEY during INIT.
- cam_addr: 0 except in INIT and WRITE.

Test Plan:
- Reset release: 16 cycles of cam_wen=1 with cam_addr 0..15 and cam_din=8'hFF; req_ready=1 in cycle 16; count=0.
- Insert 8'h3C: rsp_hit=0, rsp_new=1, rsp_addr=0, count=1, rsp_valid 4 cycles after accept. Repeat insert 8'h3C: rsp_hit=1, rsp_new=0, rsp_addr=0, no cam_wen, count stays 1.
- Insert 8'h10, 8'h20: land in slots 1 and 2. Search 8'h20 -> rsp_hit=1, rsp_addr=2 in cycle 3. Search 8'h55 -> rsp_hit=0.
- Fill 16 distinct keys -> full=1, count=16. Insert new 8'h99 -> rsp_full=1, rsp_new=0, no cam_wen. Insert an existing key -> normal hit.
- Hold rsp_ready low 5 cycles -> rsp fields stable and req_ready=0. Then clear -> 16 INIT writes, count=0, full=0; a search for a previously stored key misses.
- Search key 8'hFF and op 11 -> rsp_err=1 in cycle 1, no cam_ren. Assert rst during WRITE -> rsp_valid=0, INIT restarts at addr 0.
